// File: rtl/rf_pkg.sv
// Shared defaults and the writeback request type for the register-file writeback arbiter.
package rf_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_ADDRESS_WIDTH = 5;
  localparam int unsigned DEF_NUM_REGS      = 32;
  localparam int unsigned DEF_FIFO_DEPTH    = 2;

  typedef struct packed {
    logic [DEF_ADDRESS_WIDTH-1:0] dest;
    logic [DEF_DATA_WIDTH-1:0]    data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of pipeline writeback, long-latency result, hazard query and register-file write signals.
interface rf_wb_arbiter_if
  import rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned NUM_REGS      = DEF_NUM_REGS
);

  logic                     wb_valid;
  logic [ADDRESS_WIDTH-1:0] wb_dest;
  logic [DATA_WIDTH-1:0]    wb_data;

  logic                     lu_issue;
  logic [ADDRESS_WIDTH-1:0] lu_issue_dest;

  logic                     lu_valid;
  logic [ADDRESS_WIDTH-1:0] lu_dest;
  logic [DATA_WIDTH-1:0]    lu_data;
  logic                     lu_ready;

  logic [ADDRESS_WIDTH-1:0] rd_addr1;
  logic [ADDRESS_WIDTH-1:0] rd_addr2;
  logic                     hazard;

  logic                     rg_wrt_en;
  logic [ADDRESS_WIDTH-1:0] rg_wrt_dest;
  logic [DATA_WIDTH-1:0]    rg_wrt_data;

  logic [NUM_REGS-1:0]      pend;
  logic                     wb_conflict;

  modport master (
    output wb_valid, wb_dest, wb_data,
    output lu_issue, lu_issue_dest,
    output lu_valid, lu_dest, lu_data,
    input  lu_ready,
    output rd_addr1, rd_addr2,
    input  hazard,
    input  rg_wrt_en, rg_wrt_dest, rg_wrt_data,
    input  pend, wb_conflict
  );

  modport slave (
    input  wb_valid, wb_dest, wb_data,
    input  lu_issue, lu_issue_dest,
    input  lu_valid, lu_dest, lu_data,
    output lu_ready,
    input  rd_addr1, rd_addr2,
    output hazard,
    output rg_wrt_en, rg_wrt_dest, rg_wrt_data,
    output pend, wb_conflict
  );

endinterface

// File: rtl/rf_wb_fifo.sv
// In-order result buffer for long-latency unit writebacks; push and pop are gated internally.
module rf_wb_fifo #(
  parameter int unsigned WIDTH      = 37,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writebacks and buffered
// long-latency results, and keeps the pending-write scoreboard used for decode hazards.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned NUM_REGS      = DEF_NUM_REGS,
  parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input logic           clk,
  input logic           rst,
  rf_wb_arbiter_if.slave bus
);

  localparam int unsigned REQ_W = ADDRESS_WIDTH + DATA_WIDTH;

  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic                     w_push;
  logic                     w_pop;
  logic [REQ_W-1:0]         w_head;
  logic [ADDRESS_WIDTH-1:0] w_head_dest;
  logic [DATA_WIDTH-1:0]    w_head_data;
  logic [NUM_REGS-1:0]      w_pend_d;

  logic [NUM_REGS-1:0]      r_pend;
  logic                     r_wrt_en;
  logic [ADDRESS_WIDTH-1:0] r_wrt_dest;
  logic [DATA_WIDTH-1:0]    r_wrt_data;
  logic                     r_conflict;

  assign w_push = bus.lu_valid && !w_fifo_full;
  assign w_pop  = !bus.wb_valid && !w_fifo_empty;
  assign {w_head_dest, w_head_data} = w_head;

  rf_wb_fifo #(
    .WIDTH      (REQ_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({bus.lu_dest, bus.lu_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Issue is applied after the pop clear so a same-register set wins.
  always_comb begin
    w_pend_d = r_pend;
    if (w_pop && (w_head_dest != '0)) begin
      w_pend_d[w_head_dest] = 1'b0;
    end
    if (bus.lu_issue && (bus.lu_issue_dest != '0)) begin
      w_pend_d[bus.lu_issue_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= '0;
      r_wrt_en   <= 1'b0;
      r_wrt_dest <= '0;
      r_wrt_data <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_pend     <= w_pend_d;
      r_conflict <= bus.wb_valid && (bus.wb_dest != '0) && r_pend[bus.wb_dest];
      if (bus.wb_valid) begin
        r_wrt_en   <= (bus.wb_dest != '0);
        r_wrt_dest <= bus.wb_dest;
        r_wrt_data <= bus.wb_data;
      end else if (!w_fifo_empty) begin
        r_wrt_en   <= (w_head_dest != '0);
        r_wrt_dest <= w_head_dest;
        r_wrt_data <= w_head_data;
      end else begin
        r_wrt_en   <= 1'b0;
      end
    end
  end

  assign bus.lu_ready    = !w_fifo_full;
  assign bus.hazard      = ((bus.rd_addr1 != '0) && r_pend[bus.rd_addr1]) ||
                           ((bus.rd_addr2 != '0) && r_pend[bus.rd_addr2]);
  assign bus.rg_wrt_en   = r_wrt_en;
  assign bus.rg_wrt_dest = r_wrt_dest;
  assign bus.rg_wrt_data = r_wrt_data;
  assign bus.pend        = r_pend;
  assign bus.wb_conflict = r_conflict;

endmodule
